lm70_scan_scheduler: RTL and testbench

Sequences LM70 SPI temperature reads across up to NUM_SENSORS sensors that share one SCK/SIO pair, each with its own chip select. It generates CS/SCK framing and captures each 16-bit frame. Per channel it stores the raw frame and a display-ready temperature clamped to 0..99 °C. It sits between the board SPI pins and the BCD/7-segment display path, which reads results through a channel-select port.

---
 rtl/lm70_scan_scheduler.sv | 164 ++++++++++++++++
 tb/tb_lm70_scan_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lm70_scan_scheduler.sv
// LM70 multi-sensor SPI scan scheduler with per-channel result storage.
// Optional over-temperature alarm flags are built when LM70_ALARM_EN is defined.
module lm70_scan_scheduler #(
    parameter int unsigned NUM_SENSORS = 4,
    parameter int unsigned SCK_DIV     = 1,
    parameter int unsigned GAP_CYCLES  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   continuous,
    input  logic                   scan_start,
    output logic [NUM_SENSORS-1:0] cs_n,
    output logic                   sck,
    input  logic                   miso,
    output logic                   busy,
    output logic                   frame_done,
    output logic [2:0]             frame_ch,
    input  logic [2:0]             rd_sel,
    output logic [15:0]            rd_raw,
    output logic [6:0]             rd_temp,
    output logic                   rd_neg,
    output logic                   rd_valid,
    output logic [NUM_SENSORS-1:0] alarm,
    input  logic [6:0]             alarm_thresh,
    input  logic                   alarm_clr
);

    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, STORE, GAP} state_t;

    state_t      state, state_next;
    logic [15:0] cnt;
    logic [4:0]  phase;
    logic [2:0]  ch;
    logic [15:0] shreg;
    logic [15:0] raw_mem  [8];
    logic [6:0]  temp_mem [8];
    logic [7:0]  neg_mem;
    logic [7:0]  valid_mem;
    logic [6:0]  temp_new;
    logic        tick, gap_done, start, last_ch, cs_active, in_range;

    assign tick     = (cnt == 16'(SCK_DIV - 1));
    assign gap_done = (cnt == 16'(GAP_CYCLES - 1));
    assign start    = en & (continuous | scan_start);
    assign last_ch  = (32'(ch) >= NUM_SENSORS - 1);

    always_comb begin
        if (shreg[15])
            temp_new = '0;
        else if (shreg[14:7] > 8'd99)
            temp_new = 7'd99;
        else
            temp_new = shreg[13:7];
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start) state_next = CS_SETUP;
            CS_SETUP: if (tick) state_next = SHIFT;
            SHIFT:    if (tick && phase == 5'd31) state_next = CS_HOLD;
            CS_HOLD:  if (tick) state_next = STORE;
            STORE:    state_next = GAP;
            GAP: begin
                // en low stops the scan after the frame in flight; CS is never cut short
                if (gap_done) begin
                    if (!en)
                        state_next = IDLE;
                    else if (!last_ch || continuous)
                        state_next = CS_SETUP;
                    else
                        state_next = IDLE;
                end
            end
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            phase     <= '0;
            ch        <= '0;
            shreg     <= '0;
            neg_mem   <= '0;
            valid_mem <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                raw_mem[i]  <= '0;
                temp_mem[i] <= '0;
            end
        end else begin
            if (state_next != state || (state == SHIFT && tick))
                cnt <= '0;
            else
                cnt <= cnt + 16'd1;
            case (state)
                IDLE:     if (start) ch <= '0;
                CS_SETUP: phase <= '0;
                SHIFT: begin
                    // even phases are sck-high; sample at the edge that ends them
                    if (tick) begin
                        phase <= phase + 5'd1;
                        if (!phase[0]) shreg <= {shreg[14:0], miso};
                    end
                end
                STORE: begin
                    raw_mem[ch]   <= shreg;
                    temp_mem[ch]  <= temp_new;
                    neg_mem[ch]   <= shreg[15];
                    valid_mem[ch] <= 1'b1;
                end
                GAP:      if (gap_done && en) ch <= last_ch ? 3'd0 : ch + 3'd1;
                default:  ;
            endcase
        end
    end

    always_comb begin
        cs_active  = (state == CS_SETUP) || (state == SHIFT) || (state == CS_HOLD);
        busy       = (state != IDLE);
        frame_done = (state == STORE);
        frame_ch   = ch;
        sck        = (state == SHIFT) && !phase[0];
        cs_n       = '1;
        for (int unsigned i = 0; i < NUM_SENSORS; i++)
            cs_n[i] = ~(cs_active && ch == 3'(i));
    end

    always_comb begin
        in_range = (32'(rd_sel) < NUM_SENSORS);
        rd_raw   = in_range ? raw_mem[rd_sel]   : '0;
        rd_temp  = in_range ? temp_mem[rd_sel]  : '0;
        rd_neg   = in_range ? neg_mem[rd_sel]   : 1'b0;
        rd_valid = in_range ? valid_mem[rd_sel] : 1'b0;
    end

`ifdef LM70_ALARM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
                if (state == STORE && ch == 3'(i) && temp_new > alarm_thresh)
                    alarm[i] <= 1'b1;
                else if (alarm_clr)
                    alarm[i] <= 1'b0;
            end
        end
    end
`else
    logic unused_alarm_inputs;
    assign unused_alarm_inputs = ^{alarm_thresh, alarm_clr};
    assign alarm = '0;
`endif

endmodule

// File: tb/tb_lm70_scan_scheduler.sv
// Scoreboard bench for lm70_scan_scheduler: default instance plus an SCK_DIV=3 instance.
module tb_lm70_scan_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, continuous = 1'b0, scan_start = 1'b0;
    logic [3:0]  cs_n;
    logic        sck, miso, busy, frame_done;
    logic [2:0]  frame_ch;
    logic [2:0]  rd_sel = 3'd0;
    logic [15:0] rd_raw;
    logic [6:0]  rd_temp;
    logic        rd_neg, rd_valid;
    logic [3:0]  alarm;
    logic [6:0]  alarm_thresh = 7'd127;
    logic        alarm_clr = 1'b0;

    logic        en3 = 1'b0, start3 = 1'b0;
    logic [0:0]  cs_n3, alarm3;
    logic        sck3, miso3, busy3, fd3, rd_neg3, rd_valid3;
    logic [2:0]  frame_ch3;
    logic [15:0] rd_raw3;
    logic [6:0]  rd_temp3;

    always #5 clk = ~clk;

    lm70_scan_scheduler #(.NUM_SENSORS(4), .SCK_DIV(1), .GAP_CYCLES(4)) u_dut (
        .clk(clk), .rst(rst), .en(en), .continuous(continuous), .scan_start(scan_start),
        .cs_n(cs_n), .sck(sck), .miso(miso), .busy(busy), .frame_done(frame_done),
        .frame_ch(frame_ch), .rd_sel(rd_sel), .rd_raw(rd_raw), .rd_temp(rd_temp),
        .rd_neg(rd_neg), .rd_valid(rd_valid), .alarm(alarm),
        .alarm_thresh(alarm_thresh), .alarm_clr(alarm_clr));

    lm70_scan_scheduler #(.NUM_SENSORS(1), .SCK_DIV(3), .GAP_CYCLES(2)) u_dut3 (
        .clk(clk), .rst(rst), .en(en3), .continuous(1'b0), .scan_start(start3),
        .cs_n(cs_n3), .sck(sck3), .miso(miso3), .busy(busy3), .frame_done(fd3),
        .frame_ch(frame_ch3), .rd_sel(3'd0), .rd_raw(rd_raw3), .rd_temp(rd_temp3),
        .rd_neg(rd_neg3), .rd_valid(rd_valid3), .alarm(alarm3),
        .alarm_thresh(7'd127), .alarm_clr(1'b0));

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Sensor models: shift out the selected word MSB first, advance on sck fall.
    logic [15:0] words [4];
    logic [15:0] cur_word;
    logic        cs_idle;
    int          bc = 0;
    assign cs_idle = &cs_n;
    always_comb begin
        cur_word = '0;
        for (int i = 0; i < 4; i++) if (cs_n[i] == 1'b0) cur_word = words[i];
    end
    always @(negedge sck or posedge cs_idle) begin
        if (cs_idle !== 1'b0) bc = 0;
        else bc++;
    end
    assign miso = (!cs_idle && bc < 16) ? cur_word[15 - bc] : 1'b0;

    logic [15:0] w3 = 16'h0000;
    int          bc3 = 0;
    always @(negedge sck3 or posedge cs_n3[0]) begin
        if (cs_n3[0] !== 1'b0) bc3 = 0;
        else bc3++;
    end
    assign miso3 = (!cs_n3[0] && bc3 < 16) ? w3[15 - bc3] : 1'b0;

    // SCK_DIV=3 waveform observer
    int run3 = 0, phases3 = 0, badlen3 = 0, badedge3 = 0;
    logic cs_prev3 = 1'b1;
    always @(negedge clk) begin
        if (sck3 === 1'b1) run3++;
        else if (run3 != 0) begin
            phases3++;
            if (run3 != 3) badlen3++;
            run3 = 0;
        end
        if (cs_n3[0] !== cs_prev3) begin
            if (sck3 !== 1'b0) badedge3++;
            cs_prev3 = cs_n3[0];
        end
    end

    // ch3 watcher for the en-drop test
    logic watch3 = 1'b0, ch3_seen = 1'b0;
    always @(negedge clk) if (watch3 && cs_n[3] === 1'b0) ch3_seen = 1'b1;

    typedef struct {
        logic [2:0]  ch;
        logic [15:0] raw;
        logic [6:0]  temp;
        logic        neg;
    } exp_t;
    exp_t q[$];
    exp_t q3[$];
    int   fd_cyc[$];

    task automatic expect_frame(input logic [2:0] c, input logic [15:0] r,
                                input logic [6:0] t, input logic n);
        exp_t e;
        e.ch = c; e.raw = r; e.temp = t; e.neg = n;
        q.push_back(e);
    endtask

    // Monitor: frame_done pops the scoreboard; stored results read back next cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                fd_cyc.push_back(cyc);
                if (q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_frame: got frame_ch %0d, expected no frame", frame_ch);
                end else begin
                    e = q.pop_front();
                    check("frame_ch", 32'(frame_ch), 32'(e.ch));
                    @(posedge clk); #1;
                    rd_sel = e.ch;
                    #1;
                    check("rd_raw", 32'(rd_raw), 32'(e.raw));
                    check("rd_temp", 32'(rd_temp), 32'(e.temp));
                    check("rd_neg", 32'(rd_neg), 32'(e.neg));
                    check("rd_valid", 32'(rd_valid), 32'd1);
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (fd3 === 1'b1) begin
                if (q3.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_frame3: got a frame, expected none");
                end else begin
                    e = q3.pop_front();
                    @(posedge clk); #1;
                    check("rd_raw3", 32'(rd_raw3), 32'(e.raw));
                    check("rd_temp3", 32'(rd_temp3), 32'(e.temp));
                    check("rd_neg3", 32'(rd_neg3), 32'(e.neg));
                end
            end
        end
    end

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        while (busy === 1'b1 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy === 1'b1) begin
            tests++; fails++;
            $display("FAIL idle_timeout: got busy after %0d cycles, expected idle", n);
        end
    endtask

    task automatic pulse_scan();
        @(negedge clk);
        en = 1'b1; scan_start = 1'b1;
        @(posedge clk); #1;
        scan_start = 1'b0;
    endtask

    initial begin
        int n;
        int k;
        exp_t e3;
        words[0] = 16'h0C80; words[1] = 16'h3200; words[2] = 16'hFB00; words[3] = 16'h0000;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", 32'(cs_n), 32'hF);
        check("rst_sck", 32'(sck), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alarm", 32'(alarm), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        @(negedge clk) rst = 1'b0;

        // Single scan, defaults; a second scan_start mid-scan must be ignored
        expect_frame(3'd0, 16'h0C80, 7'd25, 1'b0);
        expect_frame(3'd1, 16'h3200, 7'd99, 1'b0);
        expect_frame(3'd2, 16'hFB00, 7'd0, 1'b1);
        expect_frame(3'd3, 16'h0000, 7'd0, 1'b0);
        fd_cyc.delete();
        pulse_scan();
        check("first_cs_fall", 32'(cs_n), 32'hE);
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            if (n == 50) scan_start = 1'b1;
            if (n == 51) scan_start = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        scan_start = 1'b0;
        check("scan_busy_cycles", 32'(n), 32'd156);
        repeat (20) @(posedge clk);
        #1;
        check("no_second_scan", 32'(busy), 32'd0);
        check("frames_seen", 32'(fd_cyc.size()), 32'd4);
        if (fd_cyc.size() == 4) begin
            check("frame_len", 32'(fd_cyc[1] - fd_cyc[0]), 32'd39);
            check("scan_span", 32'(fd_cyc[3] - fd_cyc[0]), 32'd117);
        end
        check("queue_drained", 32'(q.size()), 32'd0);

        rd_sel = 3'd5; #1;
        check("oob_raw", 32'(rd_raw), 32'd0);
        check("oob_valid", 32'(rd_valid), 32'd0);
        rd_sel = 3'd1; #1;
        check("ch1_held_temp", 32'(rd_temp), 32'd99);

        // Continuous mode, en dropped during ch2 SHIFT
        words[0] = 16'h1400; words[1] = 16'h0080; words[2] = 16'hFF80; words[3] = 16'h0C80;
        expect_frame(3'd0, 16'h1400, 7'd40, 1'b0);
        expect_frame(3'd1, 16'h0080, 7'd1, 1'b0);
        expect_frame(3'd2, 16'hFF80, 7'd0, 1'b1);
        ch3_seen = 1'b0; watch3 = 1'b1;
        @(negedge clk);
        continuous = 1'b1; en = 1'b1;
        k = 0;
        while (!(cs_n === 4'b1011 && sck === 1'b1) && k < 500) begin
            @(negedge clk); k++;
        end
        check("reach_ch2_shift", 32'(k < 500), 32'd1);
        en = 1'b0;
        wait_idle(200, n);
        repeat (10) @(posedge clk);
        #1;
        watch3 = 1'b0;
        check("ch3_never_selected", 32'(ch3_seen), 32'd0);
        check("idle_after_drop", 32'(busy), 32'd0);
        check("queue_drained2", 32'(q.size()), 32'd0);
        continuous = 1'b0;

        // Reset during SHIFT
        pulse_scan();
        k = 0;
        while (sck !== 1'b1 && k < 50) begin
            @(negedge clk); k++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_cs_n", 32'(cs_n), 32'hF);
        check("midrst_sck", 32'(sck), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_frame_done", 32'(frame_done), 32'd0);
        for (int i = 0; i < 4; i++) begin
            rd_sel = 3'(i); #1;
            check("midrst_rd_valid", 32'(rd_valid), 32'd0);
            check("midrst_rd_raw", 32'(rd_raw), 32'd0);
        end
        @(negedge clk) rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("stay_idle_after_rst", 32'(busy), 32'd0);

        // Alarm flags (fixed at 0 unless LM70_ALARM_EN)
        words[0] = 16'h0C80; words[1] = 16'h0F80; words[2] = 16'h0000; words[3] = 16'h0000;
        alarm_thresh = 7'd30;
        expect_frame(3'd0, 16'h0C80, 7'd25, 1'b0);
        expect_frame(3'd1, 16'h0F80, 7'd31, 1'b0);
        expect_frame(3'd2, 16'h0000, 7'd0, 1'b0);
        expect_frame(3'd3, 16'h0000, 7'd0, 1'b0);
        pulse_scan();
        wait_idle(400, n);
`ifdef LM70_ALARM_EN
        check("alarm_set", 32'(alarm), 32'h2);
`else
        check("alarm_tied", 32'(alarm), 32'h0);
`endif
        words[1] = 16'h0F00;
        expect_frame(3'd0, 16'h0C80, 7'd25, 1'b0);
        expect_frame(3'd1, 16'h0F00, 7'd30, 1'b0);
        expect_frame(3'd2, 16'h0000, 7'd0, 1'b0);
        expect_frame(3'd3, 16'h0000, 7'd0, 1'b0);
        pulse_scan();
        wait_idle(400, n);
`ifdef LM70_ALARM_EN
        check("alarm_sticky", 32'(alarm), 32'h2);
`else
        check("alarm_tied2", 32'(alarm), 32'h0);
`endif
        @(negedge clk) alarm_clr = 1'b1;
        @(negedge clk) alarm_clr = 1'b0;
        check("alarm_cleared", 32'(alarm), 32'h0);

        // SCK_DIV=3 single-sensor instance
        w3 = 16'hA5C3;
        e3.ch = 3'd0; e3.raw = 16'hA5C3; e3.temp = 7'd0; e3.neg = 1'b1;
        q3.push_back(e3);
        phases3 = 0; badlen3 = 0; badedge3 = 0;
        @(negedge clk);
        en3 = 1'b1; start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        check("div3_first_cs", 32'(cs_n3), 32'd0);
        n = 0;
        while (busy3 === 1'b1 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("div3_frame_cycles", 32'(n), 32'd105);
        repeat (5) @(posedge clk);
        #1;
        check("div3_sck_phases", 32'(phases3), 32'd16);
        check("div3_bad_len", 32'(badlen3), 32'd0);
        check("div3_sck_at_cs_edge", 32'(badedge3), 32'd0);
        check("div3_queue_drained", 32'(q3.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion, expected finish");
        $fatal(1, "timeout");
    end

endmodule
